sdram_pattern_bist: RTL
=======================

Name: sdram_pattern_bist

Overview:
- Single-clock traffic generator and checker on the user side of the SDRAM controller top.
- Writes a deterministic 16-bit pattern into the controller's write FIFO, then drains the same number of words from the read FIFO and compares each against the expected pattern.
- Reports pass/fail, error count and the index of the first mismatch.
- Used for board bring-up and regression of the arbiter/write/read path. Drives wfifo_wclk and rfifo_rclk from sclk.

Parameters:
- NUM_WORDS, 256, words per test run; range 1..(write FIFO depth); must be a multiple of BURST_LEN.
- BURST_LEN, 4, words read per assertion of rfifo_rd_ready.
- TIMEOUT, 65535, maximum sclk cycles spent waiting for rfifo_rd_ready before the run aborts.
- PAT_MODE, 0, pattern select: 0 = incrementing (seed+i), 1 = walking-ones rotate-left from seed.

Ports:
- sclk  in  1  system clock, 100 MHz.
- s_rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a run; ignored while busy.
- seed  in  16  pattern seed, sampled on the accepted start.
- wfifo_wr_en  out  1  write strobe into the write FIFO.
- wfifo_wr_data  out  16  pattern word.
- rfifo_rd_en  out  1  read strobe to the read FIFO.
- rfifo_rd_data  in  16  read FIFO data, valid the cycle after rfifo_rd_en.
- rfifo_rd_ready  in  1  high when at least BURST_LEN words are readable.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at run end.
- pass  out  1  result of the last run; held until the next accepted start.
- timeout  out  1  last run aborted on timeout; held until the next accepted start.
- err_cnt  out  16  mismatches in the last run; saturates at 16'hFFFF.
- first_err_idx  out  16  word index of the first mismatch; 16'hFFFF if there was none.

Behaviour:
- Reset values: all outputs 0, except first_err_idx = 16'hFFFF. The FSM returns to IDLE. A reset mid-run abandons the run with no done pulse.
- FSM is one-hot: IDLE, WRITE, WAIT_RD, READ, FINISH.
- IDLE:
  - On start, latch seed.
  - Clear err_cnt, pass and timeout; set first_err_idx = FFFF.
  - Set wr_idx = rd_idx = 0 and busy = 1. Next state is WRITE.
- WRITE:
  - Assert wfifo_wr_en for exactly NUM_WORDS consecutive cycles; wfifo_wr_data = pat(wr_idx).
  - After the last word, go to WAIT_RD. wfifo_wr_en is low in WAIT_RD.
- Pattern function:
  - Mode 0: pat(i) = seed + i, modulo 2^16.
  - Mode 1: pat(i) = seed rotated left by (i mod 16).
- WAIT_RD:
  - The timeout counter increments each cycle and is cleared on entry.
  - If rfifo_rd_ready is high, go to READ.
  - If the counter reaches TIMEOUT first, set timeout = 1 and go to FINISH.
  - If ready rises on the same cycle the count expires, ready wins.
- READ:
  - Assert rfifo_rd_en for exactly BURST_LEN consecutive cycles.
  - The compare pipeline checks the registered rfifo_rd_data one cycle after each strobe against pat(rd_idx_d1).
  - After the burst, if words read < NUM_WORDS, return to WAIT_RD with the timeout counter cleared.
  - Otherwise go to FINISH, but only after the final compare has retired (one extra cycle).
- Mismatch:
  - err_cnt increments, saturating at 16'hFFFF.
  - first_err_idx is written only while it equals FFFF; a true mismatch at index FFFF is indistinguishable and accepted.
- FINISH (one cycle):
  - Pulse done; busy = 0.
  - pass = (err_cnt == 0) && !timeout, computed including the last compare.
  - Next state is IDLE.
- start while busy is ignored. start on the FINISH cycle is ignored; it is accepted from IDLE on the next cycle.
- Counters are 16 bits and compare against NUM_WORDS; NUM_WORDS = 1 with BURST_LEN = 1 must work.

Decomposition:
- Shared package sdram_bist_pkg holds:
  - state localparams (5-bit one-hot);
  - PAT_INC and PAT_WALK constants;
  - a pat_gen function (seed, idx, mode) → 16 bits, reused by the generator and the checker.
- One natural sub-module, sdram_bist_checker: registered compare, err_cnt, first_err_idx. Fed by rd_valid_d1, rd_idx_d1 and data.

Test Plan:
- Loopback model (ideal FIFO; ready once ≥4 words stored), seed = 16'h1234, NUM_WORDS = 8, mode 0 → writes 1234..123B, 8 reads in 2 bursts, done with pass = 1, err_cnt = 0, first_err_idx = FFFF.
- Same setup, with the model corrupting word index 5 to 16'h0000 → pass = 0, err_cnt = 1, first_err_idx = 5.
- Seed = 16'hFFFE, mode 0 → data wraps: FFFE, FFFF, 0000, 0001, …; pass = 1.
- rfifo_rd_ready held low, TIMEOUT = 100 → done occurs 100 cycles after WAIT_RD entry, with timeout = 1 and pass = 0.
- start pulsed mid-WRITE, plus s_rst asserted mid-READ → start has no effect; after reset all outputs are at reset values with no done pulse; a new start then completes with pass = 1.
- Mode 1, seed = 16'h0001, NUM_WORDS = 20 → word 16 = 0001 again; all words match and pass = 1.

Source files
------------

// File: rtl/sdram_bist_pkg.sv
// Shared types and the pattern generator used by the SDRAM pattern BIST.
// The generator and the checker both call pat_gen, so they cannot drift apart.
package sdram_bist_pkg;

   // One-hot run sequencer states
   typedef enum logic [4:0] {
      ST_IDLE    = 5'b00001,
      ST_WRITE   = 5'b00010,
      ST_WAIT_RD = 5'b00100,
      ST_READ    = 5'b01000,
      ST_FINISH  = 5'b10000
   } bist_state_e;

   localparam logic PAT_INC  = 1'b0;   // seed + i
   localparam logic PAT_WALK = 1'b1;   // seed rotated left by i mod 16

   // Expected data word for index idx of a run started with seed
   function automatic logic [15:0] pat_gen(input logic [15:0] seed,
                                           input logic [15:0] idx,
                                           input logic        mode);
      logic [3:0]  sh;
      logic [15:0] res;
      sh = idx[3:0];
      if (mode == PAT_WALK) begin
         // A zero rotate shifts right by 16, which contributes nothing
         res = (seed << sh) | (seed >> (5'd16 - {1'b0, sh}));
      end else begin
         res = seed + idx;
      end
      return res;
   endfunction

endpackage

// File: rtl/sdram_bist_checker.sv
// Read-side checker: compares each returned word against the expected pattern
// and accumulates the error count and the index of the first mismatch.
module sdram_bist_checker
   import sdram_bist_pkg::*;
#(
   parameter logic PAT_SEL = PAT_INC
) (
   input  logic        sclk,
   input  logic        s_rst,
   input  logic        clr,
   input  logic [15:0] seed,
   input  logic        rd_valid_d1,
   input  logic [15:0] rd_idx_d1,
   input  logic [15:0] rd_data,
   output logic [15:0] err_cnt,
   output logic [15:0] first_err_idx,
   output logic        err_free_s
);

   logic mismatch_s;

   // Mismatch on the word returned for the previous strobe; err_free_s folds in the compare in flight
   always_comb begin
      mismatch_s = 1'b0;
      if (rd_valid_d1) begin
         mismatch_s = (rd_data != pat_gen(seed, rd_idx_d1, PAT_SEL));
      end else begin
         mismatch_s = 1'b0;
      end
      err_free_s = (err_cnt == 16'h0000) && !mismatch_s;
   end

   // Saturating error count and first-mismatch capture, cleared on an accepted start
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         err_cnt       <= 16'h0000;
         first_err_idx <= 16'hFFFF;
      end else if (clr) begin
         err_cnt       <= 16'h0000;
         first_err_idx <= 16'hFFFF;
      end else if (mismatch_s) begin
         if (err_cnt != 16'hFFFF) begin
            err_cnt <= err_cnt + 16'h0001;
         end
         if (first_err_idx == 16'hFFFF) begin
            first_err_idx <= rd_idx_d1;
         end
      end
   end

endmodule

// File: rtl/sdram_pattern_bist.sv
// SDRAM controller traffic BIST: writes NUM_WORDS pattern words into the write
// FIFO, then drains them back from the read FIFO in BURST_LEN bursts and checks them.
module sdram_pattern_bist
   import sdram_bist_pkg::*;
#(
   parameter int NUM_WORDS = 256,
   parameter int BURST_LEN = 4,
   parameter int TIMEOUT   = 65535,
   parameter int PAT_MODE  = 0
) (
   input  logic        sclk,
   input  logic        s_rst,
   input  logic        start,
   input  logic [15:0] seed,
   output logic        wfifo_wr_en,
   output logic [15:0] wfifo_wr_data,
   output logic        rfifo_rd_en,
   input  logic [15:0] rfifo_rd_data,
   input  logic        rfifo_rd_ready,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        timeout,
   output logic [15:0] err_cnt,
   output logic [15:0] first_err_idx
);

   localparam logic        PAT_SEL    = (PAT_MODE == 0) ? PAT_INC : PAT_WALK;
   localparam logic [15:0] LAST_IDX   = 16'(NUM_WORDS - 1);
   localparam logic [15:0] BURST_LAST = 16'(BURST_LEN - 1);
   localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT - 1);

   bist_state_e state_r;
   logic [15:0] seed_r;
   logic [15:0] wr_idx_r;
   logic [15:0] rd_idx_r;
   logic [15:0] burst_cnt_r;
   logic [15:0] tmo_cnt_r;
   logic        rd_valid_d1_r;
   logic [15:0] rd_idx_d1_r;
   logic        start_acc_s;
   logic        err_free_s;

   assign start_acc_s = (state_r == ST_IDLE) && start;

   // Run sequencer with registered FIFO strobes and status outputs
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         state_r       <= ST_IDLE;
         seed_r        <= 16'h0000;
         wr_idx_r      <= 16'h0000;
         rd_idx_r      <= 16'h0000;
         burst_cnt_r   <= 16'h0000;
         tmo_cnt_r     <= 16'h0000;
         wfifo_wr_en   <= 1'b0;
         wfifo_wr_data <= 16'h0000;
         rfifo_rd_en   <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
         pass          <= 1'b0;
         timeout       <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  seed_r        <= seed;
                  pass          <= 1'b0;
                  timeout       <= 1'b0;
                  wr_idx_r      <= 16'h0000;
                  rd_idx_r      <= 16'h0000;
                  busy          <= 1'b1;
                  wfifo_wr_en   <= 1'b1;
                  wfifo_wr_data <= pat_gen(seed, 16'h0000, PAT_SEL);
                  state_r       <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               // wr_idx_r is the index of the word currently presented
               if (wr_idx_r == LAST_IDX) begin
                  wfifo_wr_en <= 1'b0;
                  tmo_cnt_r   <= 16'h0000;
                  state_r     <= ST_WAIT_RD;
               end else begin
                  wr_idx_r      <= wr_idx_r + 16'h0001;
                  wfifo_wr_data <= pat_gen(seed_r, wr_idx_r + 16'h0001, PAT_SEL);
               end
            end
            ST_WAIT_RD: begin
               // Ready is tested first so it wins over an expiring count
               if (rfifo_rd_ready) begin
                  rfifo_rd_en <= 1'b1;
                  burst_cnt_r <= 16'h0000;
                  state_r     <= ST_READ;
               end else if (tmo_cnt_r == TMO_LAST) begin
                  timeout <= 1'b1;
                  pass    <= 1'b0;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= ST_FINISH;
               end else begin
                  tmo_cnt_r <= tmo_cnt_r + 16'h0001;
               end
            end
            ST_READ: begin
               if (rfifo_rd_en) begin
                  rd_idx_r <= rd_idx_r + 16'h0001;
                  if (burst_cnt_r == BURST_LAST) begin
                     rfifo_rd_en <= 1'b0;
                     if (rd_idx_r != LAST_IDX) begin
                        tmo_cnt_r <= 16'h0000;
                        state_r   <= ST_WAIT_RD;
                     end
                  end else begin
                     burst_cnt_r <= burst_cnt_r + 16'h0001;
                  end
               end else begin
                  // Drain cycle: the last compare retires now and is folded into pass
                  pass    <= err_free_s;
                  busy    <= 1'b0;
                  done    <= 1'b1;
                  state_r <= ST_FINISH;
               end
            end
            ST_FINISH: begin
               state_r <= ST_IDLE;
            end
            default: begin
               wfifo_wr_en <= 1'b0;
               rfifo_rd_en <= 1'b0;
               busy        <= 1'b0;
               state_r     <= ST_IDLE;
            end
         endcase
      end
   end

   // Delay the read strobe and its index to line up with the returned data
   always_ff @(posedge sclk or posedge s_rst) begin
      if (s_rst) begin
         rd_valid_d1_r <= 1'b0;
         rd_idx_d1_r   <= 16'h0000;
      end else begin
         rd_valid_d1_r <= rfifo_rd_en;
         rd_idx_d1_r   <= rd_idx_r;
      end
   end

   sdram_bist_checker #(
      .PAT_SEL (PAT_SEL)
   ) u_checker (
      .sclk          (sclk),
      .s_rst         (s_rst),
      .clr           (start_acc_s),
      .seed          (seed_r),
      .rd_valid_d1   (rd_valid_d1_r),
      .rd_idx_d1     (rd_idx_d1_r),
      .rd_data       (rfifo_rd_data),
      .err_cnt       (err_cnt),
      .first_err_idx (first_err_idx),
      .err_free_s    (err_free_s)
   );

endmodule
